imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH_BYTES, default 64, giving the instruction store size in bytes; it SHALL be a multiple of 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: one-cycle request to begin a load session.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an instruction word is offered.
REQ-006 The block SHALL have port in_word, input, 32 bits: the offered instruction encoding.
REQ-007 The block SHALL have port in_last, input, 1 bit: the offered word is the final word of the session.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-009 The block SHALL have port mem_wr_en, output, 1 bit: byte write strobe to the instruction store.
REQ-010 The block SHALL have port mem_wr_addr, output, 64 bits: byte address, same address space as the fetch PC.
REQ-011 The block SHALL have port mem_wr_data, output, 8 bits: byte to write.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE; holds the CPU off the store.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky; words were dropped this session.
REQ-015 The block SHALL have port word_count, output, 16 bits: words written this session.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT, WRITE, DRAIN and DONE.
REQ-017 In IDLE, start=1 SHALL clear the address pointer, word_count and overflow, then enter WAIT; start in any other state SHALL be ignored.
REQ-018 In WAIT, in_ready SHALL be 1; a handshake is in_valid and in_ready in the same cycle; in_word and in_last SHALL be latched on it, and the state SHALL become WRITE with byte index 0.
REQ-019 In WAIT without in_valid, the FSM SHALL hold with no memory write.
REQ-020 WRITE SHALL last exactly 4 cycles with mem_wr_en=1 and in_ready=0.
REQ-021 On byte index i (0..3), mem_wr_addr SHALL be pointer+i and mem_wr_data SHALL be word[31-8i:24-8i], i.e. big-endian, most significant byte at the lowest address.
REQ-022 After byte 3, the pointer SHALL advance by 4 and word_count by 1.
REQ-023 After byte 3 with the latched last flag set, the FSM SHALL enter DONE.
REQ-024 After byte 3 without last, the FSM SHALL enter DRAIN if pointer+4 reaches DEPTH_BYTES, else WAIT.
REQ-025 In DRAIN, in_ready SHALL be 1, no writes SHALL occur, and every accepted word SHALL set overflow and not count; accepting a word with in_last=1 SHALL enter DONE.
REQ-026 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-027 When a last word exactly fills the store, the FSM SHALL enter DONE with overflow=0.
REQ-028 Latency SHALL be 1 handshake cycle plus 4 write cycles per word; the minimum spacing between accepted words is 5 cycles.
REQ-029 in_ready SHALL be 0 in IDLE, WRITE and DONE; in_valid and in_word SHALL be ignored in those states.
REQ-030 mem_wr_addr SHALL be zero-extended to 64 bits; mem_wr_en SHALL be 0 in every state except WRITE.

Reset
REQ-031 Reset SHALL force state IDLE, in_ready=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0, overflow=0 and word_count=0.
REQ-032 Reset asserted mid-WRITE SHALL suppress mem_wr_en from the next edge, with no partial-word completion.
REQ-033 Reset SHALL take priority over start and in_valid in the same cycle.

Verification
REQ-034 Scenario: start, then one word 0xF84083E1 with in_last=1 -> writes F8@0, 40@1, 83@2, E1@3 on consecutive cycles; done pulses once; word_count=1; overflow=0.
REQ-035 Scenario: 16 words 0xF84083E1..0x8A0B014C, last on word 16 -> 64 writes; byte 63=0x4C; done pulses; overflow=0; word_count=16.
REQ-036 Scenario: 18 words, last on word 18 -> writes stop after address 63; words 17-18 are accepted and dropped; overflow=1; word_count=16.
REQ-037 Scenario: in_valid held low for 10 cycles in WAIT, then one word -> no mem_wr_en during the gap; in_ready stays 1 until the handshake.
REQ-038 Scenario: reset asserted on byte index 2 of word 0x8B030022 -> mem_wr_en=0 next cycle; all outputs at reset values; a fresh start writes again from address 0.
REQ-039 Scenario: start pulsed during WRITE -> ignored; pointer and word_count unaffected.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
// Streams 32-bit instruction words into a byte-wide instruction store.
// Each accepted word is written as four bytes, most significant byte first,
// at consecutive addresses. Words offered after the store is full are
// accepted and dropped, and the session is flagged with a sticky overflow.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : synchronous, active-high
//   start       : one-cycle request to open a load session (honoured in IDLE only)
//   in_valid    : an instruction word is offered
//   in_word     : offered instruction encoding
//   in_last     : offered word is the final word of the session
//   in_ready    : word is accepted this cycle (WAIT and DRAIN only)
//   mem_wr_en   : byte write strobe to the instruction store
//   mem_wr_addr : byte address, zero-extended to the 64-bit fetch address space
//   mem_wr_data : byte to write
//   busy        : high in every state except IDLE
//   done        : one-cycle completion pulse
//   overflow    : sticky, words were dropped this session
//   word_count  : words written this session
module imem_loader #(
  parameter int DEPTH_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_word,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_wr_en,
  output logic [63:0] mem_wr_addr,
  output logic [7:0]  mem_wr_data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] word_count
);

  // Pointer must be able to hold DEPTH_BYTES itself so the "full" compare works.
  localparam int PW = $clog2(DEPTH_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [PW-1:0]  ptr_reg;
  logic [1:0]     idx_reg;
  logic [31:0]    word_reg;
  logic           last_reg;
  logic           ovf_reg;
  logic [15:0]    count_reg;

  logic [PW-1:0]  ptr_plus4;
  logic           handshake;
  logic [7:0]     lane [4];

  assign ptr_plus4 = ptr_reg + PW'(4);
  assign handshake = in_valid && in_ready;

  // Byte lanes in write order: lane 0 is the most significant byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = word_reg[31-8*gi -: 8];
  end

  // State register and session datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      word_reg  <= '0;
      last_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            ptr_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (handshake) begin
            word_reg <= in_word;
            last_reg <= in_last;
            idx_reg  <= '0;
          end
        end
        S_WRITE: begin
          idx_reg <= idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            ptr_reg   <= ptr_plus4;
            count_reg <= count_reg + 16'd1;
          end
        end
        S_DRAIN: begin
          // Words arriving after the store is full are swallowed but flagged.
          if (handshake) ovf_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_WAIT;
      S_WAIT:  if (handshake) state_next = S_WRITE;
      S_WRITE: begin
        if (idx_reg == 2'd3) begin
          // A last word that exactly fills the store still ends cleanly.
          if (last_reg)                             state_next = S_DONE;
          else if (ptr_plus4 == PW'(DEPTH_BYTES))   state_next = S_DRAIN;
          else                                      state_next = S_WAIT;
        end
      end
      S_DRAIN: if (handshake && in_last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state so a reset edge
  // removes the write strobe immediately.
  always_comb begin
    in_ready    = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    busy        = (state_reg != S_IDLE);
    done        = 1'b0;
    case (state_reg)
      S_WAIT, S_DRAIN: in_ready = 1'b1;
      S_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = 64'(ptr_reg) + 64'(idx_reg);
        mem_wr_data = lane[idx_reg];
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign overflow   = ovf_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single word, full store, overflow drain,
// idle gap in WAIT, reset mid-write, and start ignored while busy.
module tb_imem_loader;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_last;
  logic        in_ready;
  logic        mem_wr_en;
  logic [63:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_BYTES(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_word     (in_word),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .word_count  (word_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Write/done observer, sampled mid-cycle.
  int         total_writes = 0;
  int         done_pulses  = 0;
  int         bad_addr     = 0;
  logic [7:0] mem_model [0:63];

  always @(negedge clk) begin
    if (mem_wr_en) begin
      total_writes <= total_writes + 1;
      mem_model[mem_wr_addr[5:0]] <= mem_wr_data;
      if (mem_wr_addr >= 64'(DEPTH)) bad_addr <= bad_addr + 1;
    end
    if (done) done_pulses <= done_pulses + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b0);
    chk1({tag, "_wr_en"}, mem_wr_en, 1'b0);
    chkv({tag, "_wr_addr"}, mem_wr_addr, 64'd0);
    chkv({tag, "_wr_data"}, 64'(mem_wr_data), 64'd0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_overflow"}, overflow, 1'b0);
    chkv({tag, "_count"}, 64'(word_count), 64'd0);
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk1("start_busy", busy, 1'b1);
    chk1("start_ready", in_ready, 1'b1);
  endtask

  // Hand over one word in WAIT, then check the four byte writes.
  // start_at >= 0 pulses start during that byte cycle.
  task automatic send_word(input logic [31:0] w, input logic last, input int base, input int start_at);
    logic [31:0] sh;
    chk1("hs_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    tick;
    in_valid = 1'b0;
    in_word  = 32'hDEAD_BEEF;
    in_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sh = w >> (24 - 8 * i);
      chk1("wr_en", mem_wr_en, 1'b1);
      chkv("wr_addr", mem_wr_addr, 64'(base + i));
      chkv("wr_data", 64'(mem_wr_data), 64'(sh[7:0]));
      chk1("wr_ready", in_ready, 1'b0);
      if (i == start_at) start = 1'b1;
      tick;
      start = 1'b0;
    end
  endtask

  logic [31:0] words [0:17];
  int w0, d0;

  initial begin
    words = '{32'hF84083E1, 32'h91000421, 32'hD2800020, 32'hF9400001,
              32'hAA0103E2, 32'h8B020020, 32'hCB010000, 32'hB4000061,
              32'hD1000421, 32'h17FFFFFE, 32'h52800140, 32'h1E2E1000,
              32'h910003FD, 32'hA9BF7BFD, 32'hD65F03C0, 32'h8A0B014C,
              32'h12345678, 32'hCAFEF00D};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_word = '0; in_last = 1'b0;
    tick; tick;
    chk_reset_vals("rst_hold");
    reset = 1'b0;
    tick;
    chk_reset_vals("rst_idle");

    // Single word with last
    w0 = total_writes; d0 = done_pulses;
    do_start;
    send_word(32'hF84083E1, 1'b1, 0, -1);
    chk1("s1_done", done, 1'b1);
    chk1("s1_done_busy", busy, 1'b1);
    chk1("s1_done_ready", in_ready, 1'b0);
    tick;
    chk1("s1_done_clr", done, 1'b0);
    chk1("s1_idle_busy", busy, 1'b0);
    chkv("s1_count", 64'(word_count), 64'd1);
    chk1("s1_ovf", overflow, 1'b0);
    chkv("s1_pulses", 64'(done_pulses - d0), 64'd1);
    chkv("s1_writes", 64'(total_writes - w0), 64'd4);

    // Sixteen words exactly fill the store
    w0 = total_writes; d0 = done_pulses;
    do_start;
    for (int k = 0; k < 16; k++) send_word(words[k], (k == 15), 4 * k, -1);
    chk1("s2_done", done, 1'b1);
    chk1("s2_ovf_at_done", overflow, 1'b0);
    tick;
    chkv("s2_count", 64'(word_count), 64'd16);
    chk1("s2_ovf", overflow, 1'b0);
    chkv("s2_writes", 64'(total_writes - w0), 64'd64);
    chkv("s2_byte0", 64'(mem_model[0]), 64'hF8);
    chkv("s2_byte63", 64'(mem_model[63]), 64'h4C);
    chkv("s2_pulses", 64'(done_pulses - d0), 64'd1);

    // Eighteen words: the last two are drained
    w0 = total_writes; d0 = done_pulses;
    do_start;
    for (int k = 0; k < 16; k++) send_word(words[k], 1'b0, 4 * k, -1);
    chk1("s3_drain_ready", in_ready, 1'b1);
    chk1("s3_drain_busy", busy, 1'b1);
    chk1("s3_drain_ovf0", overflow, 1'b0);
    in_valid = 1'b1; in_word = words[16]; in_last = 1'b0;
    tick;
    in_valid = 1'b0;
    chk1("s3_ovf_w17", overflow, 1'b1);
    chk1("s3_wr_en_w17", mem_wr_en, 1'b0);
    chk1("s3_ready_w17", in_ready, 1'b1);
    chkv("s3_count_w17", 64'(word_count), 64'd16);
    in_valid = 1'b1; in_word = words[17]; in_last = 1'b1;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    chk1("s3_done", done, 1'b1);
    tick;
    chk1("s3_ovf_sticky", overflow, 1'b1);
    chkv("s3_count", 64'(word_count), 64'd16);
    chkv("s3_writes", 64'(total_writes - w0), 64'd64);
    chkv("s3_bad_addr", 64'(bad_addr), 64'd0);
    chkv("s3_pulses", 64'(done_pulses - d0), 64'd1);

    // Idle gap in WAIT
    w0 = total_writes;
    do_start;
    chk1("s4_ovf_cleared", overflow, 1'b0);
    chkv("s4_count_cleared", 64'(word_count), 64'd0);
    for (int c = 0; c < 10; c++) begin
      tick;
      chk1("s4_gap_ready", in_ready, 1'b1);
      chk1("s4_gap_wr_en", mem_wr_en, 1'b0);
    end
    chkv("s4_gap_writes", 64'(total_writes - w0), 64'd0);
    send_word(32'hF84083E1, 1'b1, 0, -1);
    tick;
    chkv("s4_count", 64'(word_count), 64'd1);

    // Reset on byte index 2 of the second word, with start and in_valid high
    do_start;
    send_word(32'h11223344, 1'b0, 0, -1);
    chkv("s5_count_w1", 64'(word_count), 64'd1);
    w0 = total_writes;
    in_valid = 1'b1; in_word = 32'h8B030022; in_last = 1'b0;
    tick;
    in_valid = 1'b0;
    tick; tick;
    chkv("s5_idx2_addr", mem_wr_addr, 64'd6);
    chkv("s5_idx2_data", 64'(mem_wr_data), 64'h00);
    reset = 1'b1; start = 1'b1; in_valid = 1'b1;
    tick;
    chk_reset_vals("s5_rst");
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick;
    chk_reset_vals("s5_after");
    chkv("s5_partial_writes", 64'(total_writes - w0), 64'd3);
    do_start;
    send_word(32'h8B030022, 1'b1, 0, -1);
    tick;
    chkv("s5_count", 64'(word_count), 64'd1);

    // start pulsed during WRITE is ignored
    do_start;
    send_word(32'hD2800020, 1'b0, 0, 1);
    chkv("s6_count_w1", 64'(word_count), 64'd1);
    chk1("s6_wait_ready", in_ready, 1'b1);
    send_word(32'hD65F03C0, 1'b1, 4, -1);
    chk1("s6_done", done, 1'b1);
    tick;
    chkv("s6_count", 64'(word_count), 64'd2);
    chk1("s6_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
